keypad_digit_loader: RTL and testbench
======================================

Name: keypad_digit_loader

Overview:
Downstream stage of the keypad BCD encoder in the microwave oven controller. Consumes the encoder's bcd_out/data_valid pair and debounces each key press. Accepts exactly one digit per physical press and shifts accepted digits into a 4-digit BCD cook-time register (MM:SS, right-entry like a calculator). Feeds the countdown timer and display stages.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive clock edges a key must be stable (press) or absent (release) before acceptance; legal range 2..15
CNT_W, 4, width of the internal debounce counter; must hold DEBOUNCE_CYCLES-1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable_  input  1  active-low block enable (same polarity as encoder enable_)
clear  input  1  synchronous clear of entered time, active-high
bcd_in  input  4  digit from encoder bcd_out
data_valid  input  1  encoder data_valid
sec_ones  output  4  BCD seconds units
sec_tens  output  4  BCD seconds tens
min_ones  output  4  BCD minutes units
min_tens  output  4  BCD minutes tens
digit_count  output  3  digits entered since reset/clear, saturates at 4
key_strobe  output  1  one-cycle pulse on the cycle a digit is accepted
nonzero  output  1  high when any of the four digits is non-zero

Behaviour:
- Reset: all digit outputs 0, digit_count 0, key_strobe 0, nonzero 0, FSM IDLE, counter 0. Reset overrides every other input.
- FSM states: IDLE, PRESS, CAPTURE, RELEASE.
- IDLE: if !enable_ & data_valid & bcd_in<=9, go to PRESS, latch bcd_in into cand, counter=1. A bcd_in above 9 with data_valid is ignored.
- PRESS: if data_valid high and bcd_in==cand, counter++. When the counter reaches DEBOUNCE_CYCLES, go to CAPTURE. If data_valid drops or bcd_in!=cand, go to IDLE with counter=0.
- CAPTURE (one cycle): key_strobe=1. Shift register: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=cand. digit_count increments, saturating at 4. Next state RELEASE, counter=0.
- Latency: key_strobe is high in the cycle after the DEBOUNCE_CYCLES-th consecutive edge sampling a stable valid key. Digit registers show the new value in that same cycle.
- RELEASE: counter++ while data_valid is low. Any data_valid high resets the counter to 0. When the counter reaches DEBOUNCE_CYCLES, go to IDLE. A held key therefore produces exactly one digit.
- enable_ high: FSM forced to IDLE, counter 0, key_strobe 0. Digits and digit_count are held.
- clear (enable_ don't-care): digits 0, digit_count 0, key_strobe 0, FSM to RELEASE with counter 0. Next key must be released first. If clear and CAPTURE coincide, clear wins and no digit is loaded.
- Digits are never validated beyond <=9. Seconds tens of 6..9 are passed through; normalisation belongs to the timer stage.
- nonzero is a combinational OR over the registered digits.

Optional Feature:
ENTRY_LOCK_EN
- Defined: once digit_count==4, further CAPTURE events neither shift nor strobe, and the digits are frozen until clear/reset. FSM still cycles through RELEASE so press tracking stays consistent.
- Undefined: a fifth and later digit shifts in normally, min_tens is discarded, key_strobe pulses and digit_count stays 4.

Test Plan:
Reset: assert reset 2 cycles with data_valid=1, bcd_in=5 -> all digits 0, digit_count 0, key_strobe 0, nonzero 0 throughout and on release.
Single press: enable_=0, hold bcd_in=3 with data_valid=1 for 20 cycles -> exactly one key_strobe, 4 cycles after first sample; sec_ones=3, digit_count=1, nonzero=1.
Bounce: data_valid pattern 1,1,0,1,1,1,1 with bcd_in=7 -> no strobe on the first burst; one strobe after the 4-cycle stable run; sec_ones=7.
Entry sequence: presses 1,2,3,0, each with release >=4 cycles -> min_tens=1, min_ones=2, sec_tens=3, sec_ones=0, digit_count=4.
Fifth digit: then press 9 -> without ENTRY_LOCK_EN digits become 2,3,0,9 with a strobe; with ENTRY_LOCK_EN they stay 1,2,3,0 and no strobe.
Clear and invalid input: clear on the CAPTURE cycle -> digits 0 and no strobe. Held key produces nothing until released 4 cycles. bcd_in=4'b1111 with data_valid=1 -> no strobe. enable_=1 with valid key -> no strobe, digits held.

Source files
------------

// File: rtl/keypad_digit_loader_if.sv
// ---------------------------------------------------------------------------
// keypad_digit_loader_if
// Bundles the encoder-facing inputs and the cook-time outputs of the keypad
// digit loader.
//   master : drives enable_, clear, bcd_in, data_valid; observes the digits
//   slave  : the loader itself (consumes the inputs, drives the outputs)
// Signals:
//   enable_     active-low block enable
//   clear       synchronous clear of the entered time
//   bcd_in      digit from the encoder
//   data_valid  encoder data_valid
//   sec_ones, sec_tens, min_ones, min_tens   BCD cook-time digits
//   digit_count digits entered since reset/clear (saturates at 4)
//   key_strobe  one-cycle pulse when a digit is accepted
//   nonzero     any digit non-zero
// ---------------------------------------------------------------------------
interface keypad_digit_loader_if;
    logic       enable_;
    logic       clear;
    logic [3:0] bcd_in;
    logic       data_valid;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic [2:0] digit_count;
    logic       key_strobe;
    logic       nonzero;

    modport master (
        output enable_, clear, bcd_in, data_valid,
        input  sec_ones, sec_tens, min_ones, min_tens,
        input  digit_count, key_strobe, nonzero
    );

    modport slave (
        input  enable_, clear, bcd_in, data_valid,
        output sec_ones, sec_tens, min_ones, min_tens,
        output digit_count, key_strobe, nonzero
    );
endinterface

// File: rtl/keypad_digit_loader.sv
// ---------------------------------------------------------------------------
// keypad_digit_loader
// Debounces keypad digits coming from the BCD encoder and shifts each
// accepted digit (one per physical press) into a 4-digit MM:SS cook-time
// register, entering from the right like a calculator.
//
// Parameters:
//   DEBOUNCE_CYCLES  edges a key must be stable (press) / absent (release)
//                    before it counts; 2..15
//   CNT_W            debounce counter width, must hold DEBOUNCE_CYCLES-1
//
// Ports:
//   clk    rising-edge system clock
//   reset  synchronous active-high reset, overrides everything
//   bus    keypad_digit_loader_if.slave (encoder inputs, digit outputs)
//
// Optional feature (compile-time macro ENTRY_LOCK_EN):
//   defined   : once four digits are entered, further presses are tracked
//               but neither shift nor strobe until clear/reset
//   undefined : later digits keep shifting in, min_tens falls off the end
// ---------------------------------------------------------------------------
module keypad_digit_loader #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    keypad_digit_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        CAPTURE = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // The counter never needs to hold DEBOUNCE_CYCLES itself: the final
    // qualifying edge is recognised while the counter still reads N-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [3:0]       cand_reg;
    logic [2:0]       count_reg;
    logic             strobe_reg;

    // digits[0] = sec_ones ... digits[3] = min_tens
    logic [3:0][3:0]  digits;
    logic [3:0][3:0]  shift_src;

    logic             key_match;
    logic             press_done;
    logic             accept_ok;
    logic             load_digit;

    assign key_match  = bus.data_valid && (bus.bcd_in == cand_reg);
    assign press_done = (state_reg == PRESS) && key_match && (cnt_reg == CNT_LAST);

`ifdef ENTRY_LOCK_EN
    assign accept_ok = (count_reg != 3'd4);
`else
    assign accept_ok = 1'b1;
`endif

    // The shift happens on the edge that enters CAPTURE so the new digit is
    // visible in the same cycle as key_strobe. Clear sampled on that same
    // edge wins, so nothing is loaded.
    assign load_digit = !reset && !bus.clear && !bus.enable_ && press_done && accept_ok;

    // Each digit loads its right-hand neighbour; the rightmost loads cand.
    assign shift_src = {digits[2], digits[1], digits[0], cand_reg};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] digit_reg;

            always_ff @(posedge clk) begin
                if (reset || bus.clear) begin
                    digit_reg <= 4'd0;
                end else if (load_digit) begin
                    digit_reg <= shift_src[gi];
                end
            end

            assign digits[gi] = digit_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            cand_reg   <= 4'd0;
            count_reg  <= 3'd0;
            strobe_reg <= 1'b0;
        end else if (bus.clear) begin
            // The key that may still be down must be released first.
            state_reg  <= RELEASE;
            cnt_reg    <= '0;
            count_reg  <= 3'd0;
            strobe_reg <= 1'b0;
        end else if (bus.enable_) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            strobe_reg <= 1'b0;
        end else begin
            strobe_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.data_valid && (bus.bcd_in <= 4'd9)) begin
                        state_reg <= PRESS;
                        cand_reg  <= bus.bcd_in;
                        cnt_reg   <= CNT_W'(1);
                    end
                end
                PRESS: begin
                    if (key_match) begin
                        if (cnt_reg == CNT_LAST) begin
                            state_reg  <= CAPTURE;
                            cnt_reg    <= '0;
                            strobe_reg <= accept_ok;
                            if (accept_ok && (count_reg != 3'd4)) begin
                                count_reg <= count_reg + 3'd1;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end
                end
                CAPTURE: begin
                    state_reg <= RELEASE;
                    cnt_reg   <= '0;
                end
                RELEASE: begin
                    if (bus.data_valid) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign bus.sec_ones    = digits[0];
    assign bus.sec_tens    = digits[1];
    assign bus.min_ones    = digits[2];
    assign bus.min_tens    = digits[3];
    assign bus.digit_count = count_reg;
    assign bus.key_strobe  = strobe_reg;
    assign bus.nonzero     = |digits;

endmodule

// File: tb/tb_keypad_digit_loader.sv
// ---------------------------------------------------------------------------
// tb_keypad_digit_loader
// Directed scenarios followed by randomized key activity. A behavioural
// model keeps the accepted digits in a queue and tracks press/release runs;
// every cycle the DUT outputs are compared against it, and a few literal
// expectations pin the model itself.
// ---------------------------------------------------------------------------
module tb_keypad_digit_loader;

    localparam int D = 4;
`ifdef ENTRY_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keypad_digit_loader_if bus();

    keypad_digit_loader #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int strobe_total = 0;
    bit cmp_on = 1'b0;

    // ---------------- behavioural model ----------------
    int entered[$];       // accepted digits, oldest first, at most 4 kept
    int m_press_run = 0;  // consecutive matching samples of the current key
    int m_digit = 0;
    bit m_wait_rel = 1'b0;
    int m_rel_run = 0;
    bit m_cap = 1'b0;     // the cycle after an acceptance decision
    bit m_strobe = 1'b0;

    function automatic int mdig(int k);
        int idx;
        idx = entered.size() - 1 - k;
        return (idx < 0) ? 0 : entered[idx];
    endfunction

    function automatic logic [20:0] model_pack();
        logic [3:0] d0, d1, d2, d3;
        d0 = 4'(mdig(0)); d1 = 4'(mdig(1)); d2 = 4'(mdig(2)); d3 = 4'(mdig(3));
        return {d3, d2, d1, d0, 3'(entered.size()), m_strobe, |{d3, d2, d1, d0}};
    endfunction

    function automatic logic [20:0] dut_pack();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones,
                bus.digit_count, bus.key_strobe, bus.nonzero};
    endfunction

    task automatic model_step(bit r, bit clr, bit en_n, bit dv, int bcd);
        if (r) begin
            entered.delete();
            m_strobe = 0; m_press_run = 0; m_wait_rel = 0; m_rel_run = 0; m_cap = 0;
        end else if (clr) begin
            entered.delete();
            m_strobe = 0; m_press_run = 0; m_wait_rel = 1; m_rel_run = 0; m_cap = 0;
        end else if (en_n) begin
            m_strobe = 0; m_press_run = 0; m_wait_rel = 0; m_rel_run = 0; m_cap = 0;
        end else if (m_cap) begin
            m_cap = 0; m_strobe = 0; m_wait_rel = 1; m_rel_run = 0;
        end else if (m_wait_rel) begin
            m_strobe = 0;
            if (dv) m_rel_run = 0;
            else begin
                m_rel_run++;
                if (m_rel_run == D) begin
                    m_wait_rel = 0;
                    m_rel_run = 0;
                end
            end
        end else if (m_press_run == 0) begin
            m_strobe = 0;
            if (dv && bcd <= 9) begin
                m_press_run = 1;
                m_digit = bcd;
            end
        end else begin
            m_strobe = 0;
            if (dv && bcd == m_digit) begin
                m_press_run++;
                if (m_press_run == D) begin
                    m_press_run = 0;
                    m_cap = 1;
                    if (!LOCK || entered.size() < 4) begin
                        entered.push_back(m_digit);
                        if (entered.size() > 4) void'(entered.pop_front());
                        m_strobe = 1;
                    end
                end
            end else begin
                m_press_run = 0;
            end
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_on) begin
            logic [20:0] act, exp;
            act = dut_pack();
            exp = model_pack();
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cycle_compare t=%0t dut=%h model=%h", $time, act, exp);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(bit r, bit clr, bit en_n, bit dv, int bcd);
        @(negedge clk);
        rst            = r;
        bus.clear      = clr;
        bus.enable_    = en_n;
        bus.data_valid = dv;
        bus.bcd_in     = 4'(bcd);
        @(posedge clk);
        model_step(r, clr, en_n, dv, bcd);
        #1;
        if (bus.key_strobe === 1'b1) strobe_total++;
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic press(int d);
        for (int i = 0; i < 6; i++) tick(0, 0, 0, 1, d);
        for (int i = 0; i < 6; i++) tick(0, 0, 0, 0, 0);
    endtask

    task automatic check_digits(string name, int mt, int mo, int st, int so);
        check({name, "_min_tens"}, int'(bus.min_tens), mt);
        check({name, "_min_ones"}, int'(bus.min_ones), mo);
        check({name, "_sec_tens"}, int'(bus.sec_tens), st);
        check({name, "_sec_ones"}, int'(bus.sec_ones), so);
    endtask

    initial begin
        int s0;
        int key, hold, rel;
        bus.clear = 0; bus.enable_ = 0; bus.data_valid = 1; bus.bcd_in = 4'd5;

        // Reset with a valid key present
        tick(1, 0, 0, 1, 5);
        cmp_on = 1'b1;
        tick(1, 0, 0, 1, 5);
        check("reset_outputs", int'(dut_pack()), 0);
        tick(0, 0, 0, 0, 0);
        check("after_reset_outputs", int'(dut_pack()), 0);

        // Single held press
        s0 = strobe_total;
        for (int i = 1; i <= 20; i++) begin
            tick(0, 0, 0, 1, 3);
            if (i == D - 1) check("single_no_early_strobe", int'(bus.key_strobe), 0);
            if (i == D)     check("single_strobe_latency", int'(bus.key_strobe), 1);
        end
        check("single_strobe_count", strobe_total - s0, 1);
        check("single_sec_ones", int'(bus.sec_ones), 3);
        check("single_count", int'(bus.digit_count), 1);
        check("single_nonzero", int'(bus.nonzero), 1);
        for (int i = 0; i < 6; i++) tick(0, 0, 0, 0, 0);

        // Bounce 1,1,0,1,1,1,1
        s0 = strobe_total;
        tick(0, 0, 0, 1, 7); tick(0, 0, 0, 1, 7); tick(0, 0, 0, 0, 7);
        tick(0, 0, 0, 1, 7); tick(0, 0, 0, 1, 7); tick(0, 0, 0, 1, 7);
        check("bounce_no_strobe_yet", strobe_total - s0, 0);
        tick(0, 0, 0, 1, 7);
        check("bounce_strobe", int'(bus.key_strobe), 1);
        check("bounce_sec_ones", int'(bus.sec_ones), 7);
        check("bounce_sec_tens", int'(bus.sec_tens), 3);
        for (int i = 0; i < 6; i++) tick(0, 0, 0, 0, 0);

        // Clear, then enter 1,2,3,0
        tick(0, 1, 0, 0, 0);
        check("clear_outputs", int'(dut_pack()), 0);
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0);
        press(1); press(2); press(3); press(0);
        check_digits("entry", 1, 2, 3, 0);
        check("entry_count", int'(bus.digit_count), 4);

        // Fifth digit
        s0 = strobe_total;
        press(9);
        if (LOCK) begin
            check_digits("fifth_locked", 1, 2, 3, 0);
            check("fifth_locked_strobes", strobe_total - s0, 0);
        end else begin
            check_digits("fifth_shift", 2, 3, 0, 9);
            check("fifth_shift_strobes", strobe_total - s0, 1);
        end
        check("fifth_count", int'(bus.digit_count), 4);

        // Clear coinciding with the acceptance edge, key kept held
        s0 = strobe_total;
        for (int i = 0; i < D - 1; i++) tick(0, 0, 0, 1, 5);
        tick(0, 1, 0, 1, 5);
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 1, 5);
        check("clear_capture_strobes", strobe_total - s0, 0);
        check("clear_capture_digits", int'(dut_pack()), 0);
        for (int i = 0; i < 6; i++) tick(0, 0, 0, 0, 0);
        press(6);
        check("after_clear_sec_ones", int'(bus.sec_ones), 6);
        check("after_clear_count", int'(bus.digit_count), 1);

        // Invalid code and disabled block
        s0 = strobe_total;
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 1, 15);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick(0, 0, 1, 1, 8);
        tick(0, 0, 0, 0, 0);
        check("invalid_disabled_strobes", strobe_total - s0, 0);
        check("disabled_sec_ones_held", int'(bus.sec_ones), 6);
        check("disabled_count_held", int'(bus.digit_count), 1);

        // Randomized key activity
        for (int b = 0; b < 160; b++) begin
            key  = $urandom_range(0, 11);
            hold = $urandom_range(0, 8);
            rel  = $urandom_range(0, 7);
            for (int i = 0; i < hold; i++) begin
                bit dv;
                dv = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 9) == 0) key = $urandom_range(0, 11);
                tick(0, ($urandom_range(0, 59) == 0), ($urandom_range(0, 39) == 0), dv, key);
            end
            for (int i = 0; i < rel; i++)
                tick(0, ($urandom_range(0, 79) == 0), ($urandom_range(0, 39) == 0),
                     ($urandom_range(0, 15) == 0), $urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) tick(1, 0, 0, 1, key);
        end

        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
